borrow_lookahead_sub_pipe: RTL and testbench



---
 rtl/sub_pkg.sv | 47 ++++
 rtl/borrow_lookahead_unit.sv | 19 +
 rtl/borrow_lookahead_sub_pipe.sv | 75 +++++++
 tb/tb_borrow_lookahead_sub_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// sub_pkg: operand width, segment boundaries, stage-1 payload and borrow helpers
package sub_pkg;
  localparam int OPW  = 12;
  localparam int SEG1 = 2;
  localparam int SEG2 = 4;
  localparam int SEG3 = 7;
  localparam int SEG4 = 11;
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] g;
    logic [OPW-1:0] p;
    logic           bi;
    logic           b2;
    logic           b4;
    logic           b7;
    logic           b11;
    logic           bo;
  } s1_t;
  function automatic logic la_borrow(input logic [OPW-1:0] g, input logic [OPW-1:0] p,
                                     input logic bi, input int k);
    logic acc, t;
    acc = bi;
    for (int m = 0; m < k; m++) acc &= p[m];
    for (int j = 0; j < k; j++) begin
      t = g[j];
      for (int m = j + 1; m < k; m++) t &= p[m];
      acc |= t;
    end
    return acc;
  endfunction
  // Local ripple inside one segment; only bits lo..hi-1 of the result are populated
  function automatic logic [OPW-1:0] seg_diff(input s1_t s, input int lo, input int hi, input logic cin);
    logic [OPW-1:0] r;
    logic c;
    r = '0;
    c = cin;
    for (int i = lo; i < hi; i++) begin
      r[i] = s.a[i] ^ s.b[i] ^ c;
      c = s.g[i] | (s.p[i] & c);
    end
    return r;
  endfunction
  function automatic logic [OPW-1:0] seg_pick(input s1_t s, input int lo, input int hi, input logic sel);
    return sel ? seg_diff(s, lo, hi, 1'b1) : seg_diff(s, lo, hi, 1'b0);
  endfunction
endpackage

// File: rtl/borrow_lookahead_unit.sv
// borrow_lookahead_unit: flat sum-of-products borrows into bits 2, 4, 7, 11 and borrow-out
module borrow_lookahead_unit
  import sub_pkg::*;
(
  input  logic [OPW-1:0] g,
  input  logic [OPW-1:0] p,
  input  logic           bi,
  output logic           b2,
  output logic           b4,
  output logic           b7,
  output logic           b11,
  output logic           bo
);
  assign b2  = la_borrow(g, p, bi, SEG1);
  assign b4  = la_borrow(g, p, bi, SEG2);
  assign b7  = la_borrow(g, p, bi, SEG3);
  assign b11 = la_borrow(g, p, bi, SEG4);
  assign bo  = la_borrow(g, p, bi, OPW);
endmodule

// File: rtl/borrow_lookahead_sub_pipe.sv
// borrow_lookahead_sub_pipe: 2-stage valid/ready subtractor a - b - bi with lookahead borrows.
// SUB_SIGNED_OVF_EN adds the registered signed-overflow output ovf.
module borrow_lookahead_sub_pipe
  import sub_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           bi,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] d,
  output logic           bo
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic           ovf
`endif
);
  logic           s1_valid, s1_en, s2_en;
  logic           la_b2, la_b4, la_b7, la_b11, la_bo;
  logic [OPW-1:0] g, p, nd;
  s1_t            s1, s1_n;
  assign g = ~a & b;
  assign p = ~(a ^ b);
  borrow_lookahead_unit u_la (
    .g   (g),
    .p   (p),
    .bi  (bi),
    .b2  (la_b2),
    .b4  (la_b4),
    .b7  (la_b7),
    .b11 (la_b11),
    .bo  (la_bo)
  );
  assign s1_n     = '{a, b, g, p, bi, la_b2, la_b4, la_b7, la_b11, la_bo};
  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;
  // Each segment is evaluated for both borrow-ins and the stage-1 lookahead borrow picks one
  assign nd = seg_pick(s1, 0, SEG1, s1.bi)
            | seg_pick(s1, SEG1, SEG2, s1.b2)
            | seg_pick(s1, SEG2, SEG3, s1.b4)
            | seg_pick(s1, SEG3, SEG4, s1.b7)
            | seg_pick(s1, SEG4, OPW, s1.b11);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= in_valid;
      if (s2_en) out_valid <= s1_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && s1_en) s1 <= s1_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d   <= '0;
      bo  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (s2_en && s1_valid) begin
      d   <= nd;
      bo  <= s1.bo;
`ifdef SUB_SIGNED_OVF_EN
      ovf <= (s1.a[OPW-1] ^ s1.b[OPW-1]) & (nd[OPW-1] ^ s1.a[OPW-1]);
`endif
    end
  end
endmodule

// File: tb/tb_borrow_lookahead_sub_pipe.sv
// tb_borrow_lookahead_sub_pipe: directed and random checks of the pipelined subtractor
module tb_borrow_lookahead_sub_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, bi, out_valid, out_ready, bo;
  logic [11:0] a, b, d;
`ifdef SUB_SIGNED_OVF_EN
  logic        ovf;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        bi;
    logic [11:0] d;
    logic        bo;
    logic        ovf;
  } vec_t;
  typedef struct packed {
    logic [11:0] d;
    logic        bo;
    logic        ovf;
  } exp_t;
  always #5 clk = ~clk;
  borrow_lookahead_sub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );
  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bi = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL reset_d got=%h want=000", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo got=%b want=0", bo); end
`ifdef SUB_SIGNED_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_vectors;
    vec_t v[10];
    v[0] = '{12'h005, 12'h003, 1'b0, 12'h002, 1'b0, 1'b0};
    v[1] = '{12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0};
    v[2] = '{12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1, 1'b0};
    v[3] = '{12'h5A5, 12'h5A5, 1'b1, 12'hFFF, 1'b1, 1'b0};
    v[4] = '{12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1};
    v[5] = '{12'h7FF, 12'h001, 1'b0, 12'h7FE, 1'b0, 1'b0};
    v[6] = '{12'h123, 12'h456, 1'b0, 12'hCCD, 1'b1, 1'b0};
    v[7] = '{12'h000, 12'h800, 1'b0, 12'h800, 1'b1, 1'b1};
    v[8] = '{12'hFFF, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b0};
    v[9] = '{12'hA5A, 12'h0F0, 1'b1, 12'h969, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; a = v[i].a; b = v[i].b; bi = v[i].bi;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_latency got=%b want=1", i, out_valid); end
      checks++; if (d !== v[i].d) begin errors++; $display("FAIL vec%0d_d got=%h want=%h", i, d, v[i].d); end
      checks++; if (bo !== v[i].bo) begin errors++; $display("FAIL vec%0d_bo got=%b want=%b", i, bo, v[i].bo); end
`ifdef SUB_SIGNED_OVF_EN
      checks++; if (ovf !== v[i].ovf) begin errors++; $display("FAIL vec%0d_ovf got=%b want=%b", i, ovf, v[i].ovf); end
`endif
    end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    logic [11:0] exp_d[5];
    int idx = 0, got = 0, first_stall = 0;
    exp_d[0] = 12'h101; exp_d[1] = 12'h212; exp_d[2] = 12'h323; exp_d[3] = 12'h434; exp_d[4] = 12'h545;
    for (int cyc = 1; cyc <= 30 && got < 5; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 5); a = 12'((idx + 1) * 12'h111); b = 12'h010; bi = 1'b0;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (!in_ready && first_stall == 0) first_stall = cyc;
      if (out_valid && !out_ready) begin
        checks++; if (d !== exp_d[got]) begin errors++; $display("FAIL b2b_hold_d got=%h want=%h", d, exp_d[got]); end
      end
      if (out_valid && out_ready) begin
        checks++; if (d !== exp_d[got]) begin errors++; $display("FAIL b2b_order_d%0d got=%h want=%h", got, d, exp_d[got]); end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    checks++; if (first_stall != 3) begin errors++; $display("FAIL b2b_stall_cycle got=%0d want=3", first_stall); end
    checks++; if (got != 5) begin errors++; $display("FAIL b2b_delivered got=%0d want=5", got); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_duplicate got=%b want=0", out_valid); end
  endtask
  task automatic test_reset_mid;
    int stale = 0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; a = 12'h00A; b = 12'h003; bi = 1'b0;
    @(negedge clk);
    a = 12'h00B;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_full got=%b want=1", out_valid); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flush got=%b want=0", out_valid); end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale got=%0d want=0", stale); end
    in_valid = 1'b1; a = 12'h00C; b = 12'h004; bi = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_new_valid got=%b want=1", out_valid); end
    checks++; if (d !== 12'h007) begin errors++; $display("FAIL rst_mid_new_d got=%h want=007", d); end
    @(negedge clk);
  endtask
  task automatic test_random;
    exp_t q[$];
    exp_t e;
    logic [12:0] full;
    int sent = 0;
    for (int cyc = 0; cyc < 60000 && (sent < 10000 || q.size() != 0); cyc++) begin
      @(negedge clk);
      in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      a = 12'($urandom); b = 12'($urandom); bi = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat got=%h want=none", d);
        end else begin
          e = q.pop_front();
          if (d !== e.d || bo !== e.bo) begin
            errors++; $display("FAIL rnd_result got=%h/%b want=%h/%b", d, bo, e.d, e.bo);
          end
`ifdef SUB_SIGNED_OVF_EN
          else if (ovf !== e.ovf) begin
            errors++; $display("FAIL rnd_ovf got=%b want=%b", ovf, e.ovf);
          end
`endif
        end
      end
      if (in_valid && in_ready) begin
        full = {1'b0, a} - {1'b0, b} - {12'd0, bi};
        q.push_back('{full[11:0], full[12], (a[11] ^ b[11]) & (full[11] ^ a[11])});
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++; if (sent != 10000) begin errors++; $display("FAIL rnd_sent got=%0d want=10000", sent); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d want=0", q.size()); end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
